// File: rtl/c_join_sync.sv
// Registered generalised Muller C-element join over IN_NUM masked request channels.
// Define C_JOIN_TIMEOUT_EN to build the stall watchdog; otherwise timeout is tied to 0.
module c_join_sync #(
  parameter int IN_NUM      = 4,
  parameter int TIMEOUT_CYC = 16,
  localparam int CNT_W      = $clog2(IN_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_NUM-1:0] in,
  input  logic [IN_NUM-1:0] mask,
  output logic              out,
  output logic [CNT_W-1:0]  n_arrived,
  output logic              busy,
  output logic              timeout
);

  typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} state_t;

  state_t             state_q, state_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   nArr_q, nArr_d;
  logic [IN_NUM-1:0]  active, atTarget, atNextTarget;
  logic               anyActive, allT, noneT, nextTargetHi;

  function automatic logic [CNT_W-1:0] popCount(input logic [IN_NUM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < IN_NUM; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // With every channel masked both all_t and none_t hold vacuously, so the state is frozen.
  always_comb begin
    active    = ~mask;
    anyActive = (active != '0);
    atTarget  = active & ((state_q == LO || state_q == WAIT_HI) ? in : ~in);
    allT      = (atTarget == active);
    noneT     = (atTarget == '0);
    state_d   = state_q;
    if (anyActive) begin
      case (state_q)
        LO:      if (allT) state_d = HI; else if (!noneT) state_d = WAIT_HI;
        WAIT_HI: if (allT) state_d = HI; else if (noneT)  state_d = LO;
        HI:      if (allT) state_d = LO; else if (!noneT) state_d = WAIT_LO;
        WAIT_LO: if (allT) state_d = LO; else if (noneT)  state_d = HI;
        default: state_d = LO;
      endcase
    end
    nextTargetHi = (state_d == LO || state_d == WAIT_HI);
    atNextTarget = active & (nextTargetHi ? in : ~in);
    nArr_d       = popCount(atNextTarget);
    out_d        = (state_d == HI || state_d == WAIT_LO);
    busy_d       = (state_d == WAIT_HI || state_d == WAIT_LO);
  end

  // Values of TIMEOUT_CYC below 2 are out of range and are not given any special handling.
  if (TIMEOUT_CYC < 2) begin : g_timeoutCfgLow
  end

`ifdef C_JOIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wdog_q, wdog_d, wdogInc;
  logic          timeout_q, timeout_d;

  // timeout is judged on the state being left, so it lingers one cycle past the end of a stall.
  always_comb begin
    wdogInc   = (wdog_q == TW'(TIMEOUT_CYC)) ? wdog_q : wdog_q + 1'b1;
    wdog_d    = (anyActive && busy_d) ? wdogInc : '0;
    timeout_d = anyActive && busy_q && (wdogInc == TW'(TIMEOUT_CYC));
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LO;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      nArr_q    <= '0;
`ifdef C_JOIN_TIMEOUT_EN
      wdog_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      nArr_q    <= nArr_d;
`ifdef C_JOIN_TIMEOUT_EN
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign n_arrived = nArr_q;

endmodule

// File: doc/c_join_sync.md
# c_join_sync

Clocked, parametrised successor to the combinational C-element tree: an IN_NUM-input generalised Muller C-element join with per-channel masking, arrival counting and an optional stall watchdog. It sits at the boundary where bundled-data handshake channels enter the synchronous control domain, converting N request levels into one joined request. The block is registered, so every output is glitch-free.

## Interface
- IN_NUM, 4: number of joined channels, 1..32.
- TIMEOUT_CYC, 16: watchdog stall limit in clock cycles, ≥2; used only with the watchdog compiled in.
- CNT_W, derived: width to hold 0..IN_NUM, i.e. clog2(IN_NUM+1).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  IN_NUM  per-channel request levels, already synchronised to clk.
- mask  in  IN_NUM  1 means the channel is ignored by the join. Sampled every cycle.
- out  out  1  joined C-element output, registered.
- n_arrived  out  CNT_W  registered count of unmasked channels whose level equals the current target level.
- busy  out  1  registered; high while in a WAIT state.
- timeout  out  1  registered; high while a stall has lasted ≥ TIMEOUT_CYC cycles.

## Operation
- Target level: 1 when out=0, 0 when out=1.
- Active set A = ~mask. all_t: every channel in A is at the target. none_t: no channel in A is at the target.
- States: LO (out=0, no arrivals), WAIT_HI (out=0, partial arrivals), HI (out=1), WAIT_LO (out=1, partial departures).
- Transitions are evaluated each cycle on the current in and mask:
  - LO → HI if all_t; LO → WAIT_HI if neither all_t nor none_t; otherwise stay.
  - WAIT_HI → HI if all_t; WAIT_HI → LO if none_t (all requests withdrawn); otherwise stay.
  - HI and WAIT_LO mirror LO and WAIT_HI with the levels swapped.
- out = 1 in HI and WAIT_LO; out = 0 in LO and WAIT_HI.
- All channels masked (A empty): the state holds, out holds, n_arrived = 0, and the watchdog is cleared.
- Masking a straggler in WAIT_* completes the join on that same evaluation.
- n_arrived is the popcount over A of (in == target), computed against the target of the current state. Width is CNT_W with no overflow.
- Reset values: state LO, out 0, n_arrived 0, busy 0, timeout 0, watchdog counter 0.

## Timing
- Latency from an input change to out, busy, n_arrived and state: 1 clock. A simultaneous all-arrive goes LO → HI in one cycle without visiting WAIT_HI.
- A full 4-phase cycle (in 0→1→0 on all channels at once) toggles out 0→1→0, with each edge 1 cycle after the input edge.
- Watchdog counter:
  - Increments every cycle spent in WAIT_*.
  - Saturates at TIMEOUT_CYC.
  - Clears to 0 on any transition into LO or HI.
- timeout rises on the cycle the counter reaches TIMEOUT_CYC.
- timeout falls 1 cycle after the state leaves WAIT_*.
- timeout does not affect out or the state; the join still completes late.
- rst asserted mid-handshake: on the next edge every output returns to its reset value, regardless of in.

## Configuration
- C_JOIN_TIMEOUT_EN defined: the watchdog counter and the timeout register are built as above.
- C_JOIN_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, TIMEOUT_CYC is ignored, and all other behaviour is identical.

## Test plan
- Reset, then IN_NUM=4, mask=0, in=4'b1111 in a single cycle: out=1 and n_arrived=0 on the next cycle, busy stays 0. Then in=0 gives out=0 one cycle later.
- Staggered arrivals in=0001, 0011, 0111, 1111 on successive cycles: n_arrived = 1, 2, 3, then out=1. busy=1 for the three partial cycles, then 0.
- mask=1000, in=0111: out=1 after 1 cycle. Clearing mask while in=0111 and out=1: the block enters WAIT_LO with n_arrived=1 (channel 3 already at the target level 0).
- Withdrawal: in=0011 (WAIT_HI) then in=0000: the block returns to LO, out stays 0, busy=0.
- Watchdog with the macro defined and TIMEOUT_CYC=16: in=0001 held: timeout=1 on the cycle the counter reaches 16. Then in=1111: out=1, busy=0 next cycle, timeout=0 one cycle after the state change. With the macro undefined: timeout stays 0 throughout.
- rst pulsed while in HI with in=1111: out=0 and state LO next edge. With in=1111 and rst low, out=1 one cycle later.
